key_debounce: RTL and testbench
===============================

Name: key_debounce

Overview:
Upstream input stage for the LED pattern logic. Samples KEY_NUM active-low board push-buttons and synchronises each to sys_clk. Filters contact bounce per key and produces a clean level plus single-cycle press/release event pulses. Pattern/speed controllers downstream consume these pulses as step or enable strobes.

Parameters:
KEY_NUM, 2, number of independent keys; each key has its own synchroniser, counter and FSM.
DEBOUNCE_CNT, 32'd1_000_000, stable cycles required before accepting a level change (20 ms at 50 MHz); legal range >= 2.
LONG_CNT, 32'd50_000_000, cycles a key must be held in PRESSED before key_long fires (1 s at 50 MHz); legal range >= 2.

Ports:
sys_clk  input  1  system clock, all logic on rising edge
sys_rst_n  input  1  asynchronous active-low reset
key_in  input  KEY_NUM  raw button inputs, active-low (0 = pressed), asynchronous to sys_clk
key_state  output  KEY_NUM  debounced level, 1 = pressed
key_press  output  KEY_NUM  one-cycle pulse on accepted press
key_release  output  KEY_NUM  one-cycle pulse on accepted release
key_long  output  KEY_NUM  one-cycle pulse when hold reaches LONG_CNT (see Optional Feature)

Behaviour:
- Reset (sys_rst_n low, asynchronous): synchroniser flops = 1 (released). FSMs = IDLE. Counters = 0. All outputs = 0. Release of reset is sampled synchronously; no events are generated by reset deassertion.
- Synchroniser: 2 flops per key; key_sync = second stage, inverted so 1 = pressed.
- Per-key FSM, 4 states:
  IDLE: key_state=0. If key_sync=1, go to PRESS_FILT with cnt=0.
  PRESS_FILT: if key_sync=0, return to IDLE with cnt=0 (bounce, no event). Else if cnt==DEBOUNCE_CNT-1, go to PRESSED and pulse key_press. Else cnt+1.
  PRESSED: key_state=1. If key_sync=0, go to REL_FILT with cnt=0.
  REL_FILT: key_state stays 1. If key_sync=1, return to PRESSED (no event; the long counter is NOT cleared). Else if cnt==DEBOUNCE_CNT-1, go to IDLE and pulse key_release. Else cnt+1.
- Outputs are registered. key_state changes in the same cycle its event pulse is asserted.
- Latency: clean edge on key_in to key_press/key_release high = exactly DEBOUNCE_CNT+3 sys_clk rising edges.
- Each pulse is exactly 1 cycle wide. Each key has at most one of press/release asserted per cycle. Keys are fully independent, so simultaneous events on different keys are allowed.
- Input glitch shorter than DEBOUNCE_CNT synchronised cycles: no event and no key_state change.
- Counters are 32-bit and never wrap: the filter counter resets on every transition; the long counter saturates.
- Reset mid-filter or mid-hold: state is discarded, no pulse is emitted. After reset, a key still physically held is detected as a fresh press.

Optional Feature:
Macro KEY_LONG_PRESS_EN.
- Defined: per-key 32-bit hold counter runs in PRESSED and REL_FILT and clears on entry to IDLE. key_long pulses 1 cycle when hold==LONG_CNT-1, then the counter saturates, giving exactly one key_long per hold. The next key_long requires a release accepted into IDLE.
- Undefined: hold counter logic is absent and key_long is tied to 0.

Test Plan:
- DEBOUNCE_CNT=4, reset held low 5 cycles with key_in=2'b00 -> all outputs 0 during reset. After release: key_press[1:0] pulses once 7 cycles later, key_state=2'b11.
- key_in[0] low for 3 cycles then high (glitch), DEBOUNCE_CNT=4 -> no key_press, key_state[0] stays 0.
- key_in[0] falls at cycle 10, clean -> key_press[0]=1 only at cycle 17. Rising edge at cycle 40 -> key_release[0]=1 only at cycle 47, key_state[0]=0 from 47.
- key_in[1] bounces 0/1 every 2 cycles for 20 cycles, then stays low -> exactly one key_press[1], 7 cycles after the last edge.
- KEY_LONG_PRESS_EN defined, LONG_CNT=16, DEBOUNCE_CNT=4, key_in[0] held low 60 cycles -> exactly one key_long[0], 16 cycles after key_press[0]. Macro undefined -> key_long=0 throughout.
- sys_rst_n pulsed low during PRESS_FILT of key 0 -> no key_press. Key still held after reset -> key_press[0] 7 cycles after reset release.

Source files
------------

// File: rtl/key_debounce_if.sv
// Key bundle between the raw button pins and the debounced level/event outputs.
// The slave modport is the debouncer side; the master modport is the consumer/driver side.
interface key_debounce_if #(
    parameter int unsigned KEY_NUM = 2
);
    logic [KEY_NUM-1:0] key_in;
    logic [KEY_NUM-1:0] key_state;
    logic [KEY_NUM-1:0] key_press;
    logic [KEY_NUM-1:0] key_release;
    logic [KEY_NUM-1:0] key_long;

    modport master (
        output key_in,
        input  key_state,
        input  key_press,
        input  key_release,
        input  key_long
    );

    modport slave (
        input  key_in,
        output key_state,
        output key_press,
        output key_release,
        output key_long
    );
endinterface

// File: rtl/key_debounce.sv
// Per-key 2-flop synchroniser, 4-state bounce filter and registered press/release pulses.
// Define KEY_LONG_PRESS_EN to add the saturating hold counter that drives key_long.
module key_debounce #(
    parameter int unsigned KEY_NUM      = 2,
    parameter logic [31:0] DEBOUNCE_CNT = 32'd1_000_000,
    parameter logic [31:0] LONG_CNT     = 32'd50_000_000
) (
    input  logic           sys_clk,
    input  logic           sys_rst_n,
    key_debounce_if.slave  key_bus
);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_FILT,
        PRESSED,
        REL_FILT
    } state_t;

    for (genvar k = 0; k < KEY_NUM; k++) begin : g_key
        logic [1:0]  sync_r;
        logic        key_sync;
        state_t      state_r;
        state_t      state_nxt;
        logic [31:0] cnt_r;
        logic [31:0] cnt_nxt;
        logic        level_r;
        logic        level_nxt;
        logic        press_r;
        logic        press_nxt;
        logic        release_r;
        logic        release_nxt;
        logic        long_r;
        logic        long_nxt;

        // Flops reset to 1 so a released key reads as released straight out of reset.
        always_ff @(posedge sys_clk or negedge sys_rst_n) begin
            if (!sys_rst_n) begin
                sync_r <= '1;
            end else begin
                sync_r <= {sync_r[0], key_bus.key_in[k]};
            end
        end

        assign key_sync = ~sync_r[1];

        always_ff @(posedge sys_clk or negedge sys_rst_n) begin
            if (!sys_rst_n) begin
                state_r   <= IDLE;
                cnt_r     <= '0;
                level_r   <= 1'b0;
                press_r   <= 1'b0;
                release_r <= 1'b0;
                long_r    <= 1'b0;
            end else begin
                state_r   <= state_nxt;
                cnt_r     <= cnt_nxt;
                level_r   <= level_nxt;
                press_r   <= press_nxt;
                release_r <= release_nxt;
                long_r    <= long_nxt;
            end
        end

        always_comb begin
            state_nxt = state_r;
            cnt_nxt   = cnt_r;
            case (state_r)
                IDLE: begin
                    if (key_sync) begin
                        state_nxt = PRESS_FILT;
                        cnt_nxt   = '0;
                    end
                end
                PRESS_FILT: begin
                    if (!key_sync) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else if (cnt_r == DEBOUNCE_CNT - 32'd1) begin
                        state_nxt = PRESSED;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt_r + 32'd1;
                    end
                end
                PRESSED: begin
                    if (!key_sync) begin
                        state_nxt = REL_FILT;
                        cnt_nxt   = '0;
                    end
                end
                REL_FILT: begin
                    if (key_sync) begin
                        state_nxt = PRESSED;
                        cnt_nxt   = '0;
                    end else if (cnt_r == DEBOUNCE_CNT - 32'd1) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt_r + 32'd1;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end

        // Event pulses are decoded from the accepting transition so they coincide with the level change.
        always_comb begin
            press_nxt   = (state_r == PRESS_FILT) && key_sync &&
                          (cnt_r == DEBOUNCE_CNT - 32'd1);
            release_nxt = (state_r == REL_FILT) && !key_sync &&
                          (cnt_r == DEBOUNCE_CNT - 32'd1);
            level_nxt   = (state_nxt == PRESSED) || (state_nxt == REL_FILT);
        end

`ifdef KEY_LONG_PRESS_EN
        logic [31:0] hold_r;
        logic [31:0] hold_nxt;
        logic        holding;

        assign holding = (state_r == PRESSED) || (state_r == REL_FILT);

        always_ff @(posedge sys_clk or negedge sys_rst_n) begin
            if (!sys_rst_n) begin
                hold_r <= '0;
            end else begin
                hold_r <= hold_nxt;
            end
        end

        // Saturates at LONG_CNT so key_long fires once per hold; only an accepted release clears it.
        always_comb begin
            hold_nxt = hold_r;
            if (state_nxt == IDLE) begin
                hold_nxt = '0;
            end else if (holding && (hold_r != LONG_CNT)) begin
                hold_nxt = hold_r + 32'd1;
            end
            long_nxt = holding && (hold_r == LONG_CNT - 32'd1);
        end
`else
        assign long_nxt = 1'b0;
`endif

        assign key_bus.key_state[k]   = level_r;
        assign key_bus.key_press[k]   = press_r;
        assign key_bus.key_release[k] = release_r;
        assign key_bus.key_long[k]    = long_r;
    end

endmodule

// File: tb/tb_key_debounce.sv
// Self-checking bench for key_debounce: directed scenarios plus randomized key activity
// compared against a run-length reference model of the debounce rules.
module tb_key_debounce;

    localparam int unsigned KN  = 2;
    localparam logic [31:0] DB  = 32'd4;
    localparam logic [31:0] LC  = 32'd16;
    localparam int          LAT = 7;
    localparam int          DBI = 4;
    localparam int          LCI = 16;

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b0;
    int   n_cmp     = 0;
    int   n_err     = 0;

    key_debounce_if #(.KEY_NUM(KN)) bus ();

    key_debounce #(
        .KEY_NUM      (KN),
        .DEBOUNCE_CNT (DB),
        .LONG_CNT     (LC)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .key_bus   (bus)
    );

    always #5 sys_clk = ~sys_clk;

    // Reference model: a level flips once the synchronised key has disagreed with it for
    // DEBOUNCE_CNT+1 consecutive edges; hold time is edges spent pressed since the press event.
    logic [KN-1:0] m_s1, m_s2, m_level, m_press, m_release, m_long;
    int            m_run  [KN];
    int            m_hold [KN];

    always @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            m_s1 = '1; m_s2 = '1;
            m_level = '0; m_press = '0; m_release = '0; m_long = '0;
            for (int k = 0; k < KN; k++) begin
                m_run[k]  = 0;
                m_hold[k] = 0;
            end
        end else begin
            for (int k = 0; k < KN; k++) begin
                logic p;
                logic old;
                p   = ~m_s2[k];
                old = m_level[k];
                m_press[k]   = 1'b0;
                m_release[k] = 1'b0;
                m_long[k]    = 1'b0;
                if (old && m_hold[k] < LCI) begin
                    m_hold[k]++;
`ifdef KEY_LONG_PRESS_EN
                    if (m_hold[k] == LCI) m_long[k] = 1'b1;
`endif
                end
                if (p != old) m_run[k]++;
                else          m_run[k] = 0;
                if (m_run[k] == DBI + 1) begin
                    m_level[k] = p;
                    m_run[k]   = 0;
                    if (p) m_press[k] = 1'b1;
                    else begin
                        m_release[k] = 1'b1;
                        m_hold[k]    = 0;
                    end
                end
            end
            m_s2 = m_s1;
            m_s1 = bus.key_in;
        end
    end

    wire [4*KN-1:0] dut_vec = {bus.key_state, bus.key_press, bus.key_release, bus.key_long};
    wire [4*KN-1:0] mdl_vec = {m_level, m_press, m_release, m_long};

    task automatic test_reset();
        int lat = -1;
        int np0 = 0, np1 = 0;
        sys_rst_n   = 1'b0;
        bus.key_in  = 2'b00;
        repeat (5) begin
            @(negedge sys_clk);
            n_cmp++;
            if (dut_vec !== 8'h00) begin
                n_err++;
                $display("FAIL reset_outputs: got %b expected %b", dut_vec, 8'h00);
            end
        end
        sys_rst_n = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge sys_clk);
            n_cmp++;
            if (dut_vec !== mdl_vec) begin
                n_err++;
                $display("FAIL reset_model: got %b expected %b cycle %0d", dut_vec, mdl_vec, c);
            end
            if (bus.key_press[0] === 1'b1) np0++;
            if (bus.key_press[1] === 1'b1) np1++;
            if (lat < 0 && bus.key_press === 2'b11) lat = c;
        end
        n_cmp++;
        if (lat != LAT) begin
            n_err++;
            $display("FAIL reset_press_latency: got %0d expected %0d", lat, LAT);
        end
        n_cmp++;
        if (np0 != 1 || np1 != 1) begin
            n_err++;
            $display("FAIL reset_press_count: got %0d/%0d expected 1/1", np0, np1);
        end
        n_cmp++;
        if (bus.key_state !== 2'b11) begin
            n_err++;
            $display("FAIL reset_key_state: got %b expected 11", bus.key_state);
        end
        bus.key_in = 2'b11;
        repeat (12) begin
            @(negedge sys_clk);
            n_cmp++;
            if (dut_vec !== mdl_vec) begin
                n_err++;
                $display("FAIL reset_release_model: got %b expected %b", dut_vec, mdl_vec);
            end
        end
    endtask

    task automatic test_glitch();
        int np = 0;
        int st = 0;
        bus.key_in[0] = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge sys_clk);
            n_cmp++;
            if (dut_vec !== mdl_vec) begin
                n_err++;
                $display("FAIL glitch_model: got %b expected %b cycle %0d", dut_vec, mdl_vec, c);
            end
            if (bus.key_press[0] === 1'b1) np++;
            if (bus.key_state[0] !== 1'b0) st++;
            if (c == 3) bus.key_in[0] = 1'b1;
        end
        n_cmp++;
        if (np != 0 || st != 0) begin
            n_err++;
            $display("FAIL glitch_no_event: got press=%0d state_high=%0d expected 0/0", np, st);
        end
    endtask

    task automatic test_clean_press_release();
        int plat = -1, rlat = -1, np = 0, nr = 0;
        bus.key_in[0] = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge sys_clk);
            n_cmp++;
            if (dut_vec !== mdl_vec) begin
                n_err++;
                $display("FAIL clean_model: got %b expected %b cycle %0d", dut_vec, mdl_vec, c);
            end
            if (bus.key_press[0] === 1'b1) begin
                np++;
                if (plat < 0) plat = c;
            end
            if (bus.key_release[0] === 1'b1) begin
                nr++;
                if (rlat < 0) rlat = c - 30;
                n_cmp++;
                if (bus.key_state[0] !== 1'b0) begin
                    n_err++;
                    $display("FAIL clean_state_at_release: got %b expected 0", bus.key_state[0]);
                end
            end
            if (c == 30) bus.key_in[0] = 1'b1;
        end
        n_cmp++;
        if (plat != LAT || np != 1) begin
            n_err++;
            $display("FAIL clean_press: got latency %0d count %0d expected %0d/1", plat, np, LAT);
        end
        n_cmp++;
        if (rlat != LAT || nr != 1) begin
            n_err++;
            $display("FAIL clean_release: got latency %0d count %0d expected %0d/1", rlat, nr, LAT);
        end
    endtask

    task automatic test_bounce();
        int np = 0, plat = -1;
        for (int seg = 0; seg < 10; seg++) begin
            bus.key_in[1] = (seg % 2 == 0) ? 1'b0 : 1'b1;
            repeat (2) begin
                @(negedge sys_clk);
                n_cmp++;
                if (dut_vec !== mdl_vec) begin
                    n_err++;
                    $display("FAIL bounce_model: got %b expected %b", dut_vec, mdl_vec);
                end
                if (bus.key_press[1] === 1'b1) np++;
            end
        end
        bus.key_in[1] = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge sys_clk);
            n_cmp++;
            if (dut_vec !== mdl_vec) begin
                n_err++;
                $display("FAIL bounce_settle_model: got %b expected %b cycle %0d", dut_vec, mdl_vec, c);
            end
            if (bus.key_press[1] === 1'b1) begin
                np++;
                if (plat < 0) plat = c;
            end
        end
        n_cmp++;
        if (np != 1 || plat != LAT) begin
            n_err++;
            $display("FAIL bounce_single_press: got count %0d latency %0d expected 1/%0d", np, plat, LAT);
        end
        bus.key_in[1] = 1'b1;
        repeat (12) @(negedge sys_clk);
    endtask

    task automatic test_long();
        int pc = -1, lc = -1, nl = 0;
        bus.key_in[0] = 1'b0;
        for (int c = 1; c <= 80; c++) begin
            @(negedge sys_clk);
            n_cmp++;
            if (dut_vec !== mdl_vec) begin
                n_err++;
                $display("FAIL long_model: got %b expected %b cycle %0d", dut_vec, mdl_vec, c);
            end
            if (bus.key_press[0] === 1'b1 && pc < 0) pc = c;
            if (bus.key_long !== 2'b00) begin
                nl++;
                if (lc < 0) lc = c;
            end
            if (c == 60) bus.key_in[0] = 1'b1;
        end
`ifdef KEY_LONG_PRESS_EN
        n_cmp++;
        if (nl != 1 || lc - pc != LCI) begin
            n_err++;
            $display("FAIL long_pulse: got count %0d gap %0d expected 1/%0d", nl, lc - pc, LCI);
        end
`else
        n_cmp++;
        if (nl != 0) begin
            n_err++;
            $display("FAIL long_disabled: got %0d pulses expected 0", nl);
        end
`endif
    endtask

    task automatic test_reset_mid_filter();
        int np = 0, plat = -1;
        bus.key_in[0] = 1'b0;
        repeat (4) begin
            @(negedge sys_clk);
            if (bus.key_press[0] === 1'b1) np++;
        end
        sys_rst_n = 1'b0;
        repeat (3) begin
            @(negedge sys_clk);
            n_cmp++;
            if (dut_vec !== 8'h00) begin
                n_err++;
                $display("FAIL midreset_outputs: got %b expected %b", dut_vec, 8'h00);
            end
        end
        n_cmp++;
        if (np != 0) begin
            n_err++;
            $display("FAIL midreset_no_press: got %0d expected 0", np);
        end
        sys_rst_n = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge sys_clk);
            n_cmp++;
            if (dut_vec !== mdl_vec) begin
                n_err++;
                $display("FAIL midreset_model: got %b expected %b cycle %0d", dut_vec, mdl_vec, c);
            end
            if (bus.key_press[0] === 1'b1 && plat < 0) plat = c;
        end
        n_cmp++;
        if (plat != LAT) begin
            n_err++;
            $display("FAIL midreset_fresh_press: got %0d expected %0d", plat, LAT);
        end
        bus.key_in = 2'b11;
        repeat (12) @(negedge sys_clk);
    endtask

    task automatic test_random();
        int left [KN];
        int nev = 0;
        for (int k = 0; k < KN; k++) left[k] = 1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge sys_clk);
            n_cmp++;
            if (dut_vec !== mdl_vec) begin
                n_err++;
                $display("FAIL random_model: got %b expected %b cycle %0d", dut_vec, mdl_vec, c);
            end
            n_cmp++;
            if ((bus.key_press & bus.key_release) !== 2'b00) begin
                n_err++;
                $display("FAIL random_exclusive: got press %b release %b expected disjoint",
                         bus.key_press, bus.key_release);
            end
            nev += $countones(m_press) + $countones(m_release);
            for (int k = 0; k < KN; k++) begin
                left[k]--;
                if (left[k] <= 0) begin
                    bus.key_in[k] = ~bus.key_in[k];
                    left[k] = $urandom_range(1, 12);
                end
            end
        end
        n_cmp++;
        if (nev == 0) begin
            n_err++;
            $display("FAIL random_activity: got %0d events expected > 0", nev);
        end
    endtask

    initial begin
        bus.key_in = '1;
        test_reset();
        test_glitch();
        test_clean_press_release();
        test_bounce();
        test_long();
        test_reset_mid_filter();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
